idct_4x4: RTL and testbench
===========================

// Module: idct_4x4
// PURPOSE
//  Inverse of the 4x4 forward DCT engine. Takes one 4x4 block of signed Q11.4 coefficients per beat and returns
//  the reconstructed 8-bit pixels, rounded and clamped, with a clip flag. Stages: input skid buffer, dequant
//  weight multiply, row transform, column transform with round/clamp. Valid/ready on both sides.
// PARAMETERS
//  PERF_OPT_ROW  0  1: row stage combinational (no register); latency -1
//  PERF_OPT_COL  0  1: column stage combinational (no register); latency -1
// PORTS
//  clk      in   1    clock; all logic on posedge
//  reset_n  in   1    synchronous, active-low reset
//  i_valid  in   1    coefficient block valid
//  i_ready  out  1    block accepted when i_valid & i_ready
//  i_data   in   256  Y[k][l] at bits [255-16*(4k+l) -:16], signed Q11.4 (1 sign, 11 int, 4 frac)
//  o_valid  out  1    pixel block valid
//  o_ready  in   1    downstream accepts when o_valid & o_ready
//  o_data   out  256  X[i][j] at bits [255-16*(4i+j) -:16]; pixel in low 8 bits, upper 8 bits zero
//  o_clip   out  1    at least one pixel of this block was clamped; qualified by o_valid
// BEHAVIOUR
//  Reset (reset_n=0 at posedge): all stage valids, o_valid, o_data, o_clip -> 0; i_ready=0 while reset_n=0,
//   i_ready=1 from the first cycle after release. Reset mid-stream discards all in-flight blocks; none emitted.
//  Input: 2-entry skid buffer; i_ready is a register output, no combinational path from o_ready.
//  Stage handshake: stage_ready = next_ready | ~stage_valid; o_data/o_clip held stable while o_valid & ~o_ready.
//  Throughput 1 block/cycle with o_ready held 1; blocks leave strictly in order; no drop or duplicate.
//  Latency (accept edge to o_valid) = 4 - PERF_OPT_ROW - PERF_OPT_COL cycles with no stalls.
//  Dequant: w[k][l] unsigned Q0.8: (k,l both even)=64 (0.25); (both odd)=26 (~0.1); mixed parity=40 (~0.158).
//   P = Y*w (Q.12, exact); Z = P >>> 6 (arithmetic, truncate) -> signed Q11.6, 18 bits.
//  Row: R[i][l] = sum_k C[k][i]*Z[k][l]; column: S[i][j] = sum_l R[i][l]*C[l][j].
//   C rows: [1 1 1 1], [2 1 -1 -2], [1 -1 -1 1], [1 -2 2 -1] (same matrix as forward; transposed use).
//   R at least 21 bits signed, S at least 24 bits signed; all sums exact (no wrap at any input value).
//  Round/clamp: p = (S + 32) >>> 6; X = 0 if p<0, 255 if p>255, else p[7:0]; o_clip = OR over 16 clamp events.
//  Bench model is bit-exact from the equations above; any valid implementation matches it exactly.
// TESTING
//  Y00=16'h2000 (512.0), others 0 -> all 16 lanes 16'h0080, o_clip=0, o_valid exactly 4 cycles after accept.
//  Y00=16'h0020 (2.0), others 0 -> Z00=0.5, rounds up: all lanes 16'h0001, o_clip=0.
//  Y00=16'hFF00 (-16.0) -> all lanes 16'h0000, o_clip=1; Y00=16'h44C0 (1100.0) -> all lanes 16'h00FF, o_clip=1.
//  16 random blocks back-to-back, o_ready pattern 1,0,0,1,... -> bit-exact vs model, in order, stable while stalled.
//  o_ready=0 for 10 cycles with i_valid=1 -> i_ready drops after pipeline+skid fill; no loss when o_ready returns.
//  reset_n low 1 cycle with 3 blocks in flight -> o_valid=0 next cycle, nothing emitted, new block has latency 4.

Source files
------------

// File: rtl/idct_4x4.sv
// 4x4 inverse DCT: skid buffer, dequant multiply, row transform, column transform with round/clamp.
// One block per beat, valid/ready on both sides; row/column registers optionally bypassed.
module idct_4x4 #(
    parameter int unsigned PERF_OPT_ROW = 0,
    parameter int unsigned PERF_OPT_COL = 0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_valid,
    output logic         i_ready,
    input  logic [255:0] i_data,
    output logic         o_valid,
    input  logic         o_ready,
    output logic [255:0] o_data,
    output logic         o_clip
);
    localparam int unsigned N  = 16;
    localparam int unsigned DW = 256;
    localparam int unsigned YW = 16;
    localparam int unsigned PW = 24;
    localparam int unsigned ZW = 18;
    localparam int unsigned RW = 21;
    localparam int unsigned SW = 24;

    // Basis matrix, CM[row][col]; rows are the forward basis vectors.
    localparam int CM [4][4] = '{'{1, 1, 1, 1}, '{2, 1, -1, -2}, '{1, -1, -1, 1}, '{1, -2, 2, -1}};

    // Dequant weight in Q0.8 chosen by the parity of (k,l); n = 4k+l.
    function automatic logic [7:0] weight(input logic [3:0] n);
        logic k_odd;
        logic l_odd;
        k_odd = n[2];
        l_odd = n[0];
        if (!k_odd && !l_odd) return 8'd64;
        else if (k_odd && l_odd) return 8'd26;
        else return 8'd40;
    endfunction

    // ---------------- input skid buffer ----------------
    logic          head_v;
    logic          skid_v;
    logic          rdy_q;
    logic [DW-1:0] head_d;
    logic [DW-1:0] skid_d;
    logic          take;
    logic          head_free;
    logic          acc1;
    logic          acc2;
    logic          acc3;

    assign take      = i_valid & rdy_q;
    assign head_free = ~head_v | acc1;
    assign i_ready   = rdy_q;

    // rdy_q tracks "skid slot will be empty next cycle", so i_ready never sees o_ready combinationally.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            head_v <= 1'b0;
            skid_v <= 1'b0;
            rdy_q  <= 1'b0;
            head_d <= '0;
            skid_d <= '0;
        end else begin
            if (head_free) begin
                if (skid_v) begin
                    head_v <= 1'b1;
                    head_d <= skid_d;
                    skid_v <= 1'b0;
                end else begin
                    head_v <= take;
                    if (take) head_d <= i_data;
                end
            end else if (take) begin
                skid_v <= 1'b1;
                skid_d <= i_data;
            end
            rdy_q <= head_free | ~(skid_v | take);
        end
    end

    // ---------------- dequant ----------------
    logic signed [PW-1:0] prod [N];
    logic signed [ZW-1:0] z_c  [N];

    always_comb begin
        for (int unsigned n = 0; n < N; n++) begin
            prod[n] = $signed(head_d[DW-1-YW*n -: YW]) * $signed({16'd0, weight(4'(n))});
            z_c[n]  = ZW'(prod[n] >>> 6);
        end
    end

    logic                 v1;
    logic signed [ZW-1:0] z1 [N];

    assign acc1 = acc2 | ~v1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            v1 <= 1'b0;
            for (int unsigned n = 0; n < N; n++) z1[n] <= '0;
        end else if (acc1) begin
            v1 <= head_v;
            if (head_v) z1 <= z_c;
        end
    end

    // ---------------- row transform: R[i][l] = sum_k C[k][i]*Z[k][l] ----------------
    logic signed [RW-1:0] r_c [N];

    always_comb begin : row_tf
        int acc;
        acc = 0;
        for (int unsigned i = 0; i < 4; i++) begin
            for (int unsigned l = 0; l < 4; l++) begin
                acc = 0;
                for (int unsigned k = 0; k < 4; k++) begin
                    acc = acc + CM[k][i] * int'(z1[4*k+l]);
                end
                r_c[4*i+l] = RW'(acc);
            end
        end
    end

    logic                 v2;
    logic signed [RW-1:0] r2 [N];

    generate
        if (PERF_OPT_ROW != 0) begin : g_row_comb
            assign v2   = v1;
            assign r2   = r_c;
            assign acc2 = acc3;
        end else begin : g_row_reg
            assign acc2 = acc3 | ~v2;
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    v2 <= 1'b0;
                    for (int unsigned n = 0; n < N; n++) r2[n] <= '0;
                end else if (acc2) begin
                    v2 <= v1;
                    if (v1) r2 <= r_c;
                end
            end
        end
    endgenerate

    // ---------------- column transform, round, clamp ----------------
    logic [DW-1:0] data_c;
    logic          clip_c;

    always_comb begin : col_tf
        int                   acc;
        int                   pv;
        logic signed [SW-1:0] s_v;
        logic [7:0]           pix;
        data_c = '0;
        clip_c = 1'b0;
        acc    = 0;
        pv     = 0;
        s_v    = '0;
        pix    = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            for (int unsigned j = 0; j < 4; j++) begin
                acc = 0;
                for (int unsigned l = 0; l < 4; l++) begin
                    acc = acc + int'(r2[4*i+l]) * CM[l][j];
                end
                s_v = SW'(acc);
                pv  = (int'(s_v) + 32) >>> 6;
                if (pv < 0) begin
                    pix    = 8'd0;
                    clip_c = 1'b1;
                end else if (pv > 255) begin
                    pix    = 8'd255;
                    clip_c = 1'b1;
                end else begin
                    pix = 8'(pv);
                end
                data_c[DW-1-YW*(4*i+j) -: YW] = {8'd0, pix};
            end
        end
    end

    generate
        if (PERF_OPT_COL != 0) begin : g_col_comb
            assign o_valid = v2;
            assign o_data  = data_c;
            assign o_clip  = clip_c;
            assign acc3    = o_ready;
        end else begin : g_col_reg
            assign acc3 = o_ready | ~o_valid;
            // Output holds while stalled; data only loads alongside a valid block.
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    o_valid <= 1'b0;
                    o_data  <= '0;
                    o_clip  <= 1'b0;
                end else if (acc3) begin
                    o_valid <= v2;
                    if (v2) begin
                        o_data <= data_c;
                        o_clip <= clip_c;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_idct_4x4.sv
// Directed and scoreboarded checks for idct_4x4: latency, hand-computed blocks, stalls,
// backpressure and mid-stream reset.
module tb_idct_4x4;
    logic         clk;
    logic         reset_n;
    logic         i_valid;
    logic         i_ready;
    logic [255:0] i_data;
    logic         o_valid;
    logic         o_ready;
    logic [255:0] o_data;
    logic         o_clip;

    int n_assert = 0;
    int n_fail   = 0;
    logic [256:0] expq [$];

    localparam int CM [4][4] = '{'{1, 1, 1, 1}, '{2, 1, -1, -2}, '{1, -1, -1, 1}, '{1, -2, 2, -1}};

    idct_4x4 dut (
        .clk     (clk),
        .reset_n (reset_n),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .i_data  (i_data),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_clip  (o_clip)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [256:0] obs, input logic [256:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Floor division, so negative values round toward minus infinity.
    function automatic int fdiv(input int v, input int m);
        if (v >= 0) return v / m;
        return -((-v + m - 1) / m);
    endfunction

    // Reference model built straight from the dequant/row/column/round equations; returns {clip, data}.
    function automatic logic [256:0] model(input logic [255:0] y);
        int z [4][4];
        int r [4][4];
        int w, s, p;
        logic [15:0]  lane;
        logic [255:0] d;
        logic         c;
        d = '0;
        c = 1'b0;
        for (int k = 0; k < 4; k++) begin
            for (int l = 0; l < 4; l++) begin
                w = ((k % 2) == 0 && (l % 2) == 0) ? 64 : (((k % 2) == 1 && (l % 2) == 1) ? 26 : 40);
                lane = y[255-16*(4*k+l) -: 16];
                z[k][l] = fdiv(int'($signed(lane)) * w, 64);
            end
        end
        for (int i = 0; i < 4; i++) begin
            for (int l = 0; l < 4; l++) begin
                r[i][l] = 0;
                for (int k = 0; k < 4; k++) r[i][l] += CM[k][i] * z[k][l];
            end
        end
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                s = 0;
                for (int l = 0; l < 4; l++) s += r[i][l] * CM[l][j];
                p = fdiv(s + 32, 64);
                if (p < 0) begin p = 0; c = 1'b1; end
                else if (p > 255) begin p = 255; c = 1'b1; end
                d[255-16*(4*i+j) -: 16] = 16'(p);
            end
        end
        return {c, d};
    endfunction

    function automatic logic [255:0] gen_blk(input int idx);
        logic [255:0] b;
        logic [15:0]  v;
        b = '0;
        for (int n = 0; n < 16; n++) begin
            if (idx % 4 == 3) v = 16'($urandom);
            else if (n == 0) v = 16'($urandom_range(0, 32'h3000));
            else v = 16'(int'($urandom_range(0, 2048)) - 1024);
            b[255-16*n -: 16] = v;
        end
        return b;
    endfunction

    // Send one block alone and check its latency, pixels and clip flag.
    task automatic send_one(input string tag, input logic [255:0] d,
                            input logic [255:0] exp_d, input logic exp_c);
        int w;
        int lat;
        w = 0;
        o_ready = 1'b1;
        i_valid = 1'b1;
        i_data  = d;
        while (!i_ready && w < 20) begin tick; w++; end
        tick;
        i_valid = 1'b0;
        i_data  = '0;
        lat = 1;
        while (!o_valid && lat < 20) begin tick; lat++; end
        chk({tag, "_latency"}, 257'(lat), 257'(4));
        chk({tag, "_data"}, 257'(o_data), 257'(exp_d));
        chk({tag, "_clip"}, 257'(o_clip), 257'(exp_c));
        tick;
        chk({tag, "_single"}, 257'(o_valid), 257'(0));
    endtask

    // Stream blocks; mode 0: o_ready=1, mode 1: o_ready 1,0,0 repeating, mode 2: o_ready=0 for 10 cycles.
    task automatic run(input string tag, input int nblk, input int mode);
        int sent, got, cyc, extra, blocked;
        logic iacc, oacc, stall;
        logic [255:0] nxt, held_d;
        logic held_c;
        logic [256:0] e;
        sent = 0; got = 0; cyc = 0; extra = 0; blocked = 0;
        nxt = gen_blk(0);
        while (got < nblk && cyc < 600) begin
            case (mode)
                0:       o_ready = 1'b1;
                1:       o_ready = (cyc % 3 == 0);
                default: o_ready = (cyc >= 10);
            endcase
            i_valid = (sent < nblk);
            i_data  = (sent < nblk) ? nxt : '0;
            iacc = i_valid & i_ready;
            oacc = o_valid & o_ready;
            if (i_valid && !i_ready) blocked++;
            if (oacc) begin
                if (expq.size() == 0) extra++;
                else begin
                    e = expq.pop_front();
                    chk({tag, "_data"}, 257'(o_data), 257'(e[255:0]));
                    chk({tag, "_clip"}, 257'(o_clip), 257'(e[256]));
                    got++;
                end
            end
            stall  = o_valid & ~o_ready;
            held_d = o_data;
            held_c = o_clip;
            tick;
            cyc++;
            if (iacc) begin
                expq.push_back(model(nxt));
                sent++;
                nxt = gen_blk(sent);
            end
            if (stall) begin
                chk({tag, "_hold_valid"}, 257'(o_valid), 257'(1));
                chk({tag, "_hold_data"}, {o_clip, o_data}, {held_c, held_d});
            end
            if (mode == 2 && cyc == 10) begin
                chk({tag, "_fill_count"}, 257'(sent), 257'(5));
                chk({tag, "_fill_ready"}, 257'(i_ready), 257'(0));
            end
        end
        i_valid = 1'b0;
        o_ready = 1'b1;
        chk({tag, "_count"}, 257'(got), 257'(nblk));
        chk({tag, "_extra"}, 257'(extra), 257'(0));
        if (mode == 0) chk({tag, "_no_block"}, 257'(blocked), 257'(0));
    endtask

    initial begin
        logic seen;
        reset_n = 1'b0;
        i_valid = 1'b0;
        i_data  = '0;
        o_ready = 1'b1;
        tick;
        tick;
        chk("rst_o_valid", 257'(o_valid), 257'(0));
        chk("rst_o_data", 257'(o_data), 257'(0));
        chk("rst_o_clip", 257'(o_clip), 257'(0));
        chk("rst_i_ready", 257'(i_ready), 257'(0));
        reset_n = 1'b1;
        tick;
        chk("rel_i_ready", 257'(i_ready), 257'(1));

        send_one("dc512", {16'h2000, 240'd0}, {16{16'h0080}}, 1'b0);
        send_one("dc2", {16'h0020, 240'd0}, {16{16'h0001}}, 1'b0);
        send_one("dc_neg", {16'hFF00, 240'd0}, {16{16'h0000}}, 1'b1);
        send_one("dc_big", {16'h44C0, 240'd0}, {16{16'h00FF}}, 1'b1);
        // Y10 = 64.0: Z = 10.0; rows scale by 2,1,-1,-2 -> pixels 20,10,0(clamped),0(clamped)
        send_one("y10", {64'd0, 16'h0400, 176'd0},
                 {{4{16'h0014}}, {4{16'h000A}}, {8{16'h0000}}}, 1'b1);

        run("b2b", 16, 0);
        run("patt", 16, 1);
        run("bp", 8, 2);

        // Three blocks in flight, then a one-cycle reset.
        o_ready = 1'b1;
        i_valid = 1'b1;
        for (int b = 0; b < 3; b++) begin
            i_data = gen_blk(b);
            tick;
        end
        reset_n = 1'b0;
        i_valid = 1'b0;
        i_data  = '0;
        tick;
        chk("mid_rst_o_valid", 257'(o_valid), 257'(0));
        chk("mid_rst_o_data", 257'(o_data), 257'(0));
        chk("mid_rst_i_ready", 257'(i_ready), 257'(0));
        reset_n = 1'b1;
        tick;
        chk("mid_rel_i_ready", 257'(i_ready), 257'(1));
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (o_valid) seen = 1'b1;
            tick;
        end
        chk("mid_rst_flushed", 257'(seen), 257'(0));
        send_one("post_rst", {16'h2000, 240'd0}, {16{16'h0080}}, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
